// File: rtl/synch_link_ctrl.sv
// Link bring-up controller: qualifies PMA signal-detect, sequences re-sync pulses,
// selects the PUDI source and tracks link status, acquisition timeouts and sync losses.
module synch_link_ctrl #(
    parameter int DEBOUNCE_CYC    = 4,
    parameter int SYNC_STABLE_CYC = 16,
    parameter int ACQ_TIMEOUT_CYC = 1024,
    parameter int CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PMA_SIGNAL_DETECT,
    input  logic [9:0]       PMA_RX_CG,
    input  logic [9:0]       TX_CG,
    input  logic             MR_LOOPBACK_REQ,
    input  logic             CODE_SYNC,
    output logic             SIGNAL_DETECT,
    output logic             SIGNAL_CHANGE,
    output logic [9:0]       PUDI,
    output logic             MR_LOOPBACK,
    output logic             LINK_STATUS,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] SYNC_LOSS_CNT
);
    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int STB_W = $clog2(SYNC_STABLE_CYC + 1);
    localparam int TMR_W = $clog2(ACQ_TIMEOUT_CYC);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYC);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(SYNC_STABLE_CYC);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACQ_TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ST_DOWN, ST_ACQ, ST_STABLE, ST_UP} state_e;

    state_e             state_q, state_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic [9:0]         pudi_q, pudi_d;
    logic               lb_q, lb_d;
    logic               link_q, link_d;
    logic               sc_q, sc_d;
    logic               to_q, to_d;

    logic eff_det, lb_toggle, qual;
    logic sc_evt, to_evt, loss_evt, tmr_clr, stb_start, stb_inc;

    // Loopback forces detect so that switching the PUDI source never drops the link to DOWN.
    assign eff_det   = MR_LOOPBACK_REQ | PMA_SIGNAL_DETECT;
    assign lb_toggle = MR_LOOPBACK_REQ ^ lb_q;

    always_comb begin
        deb_d = '0;
        if (eff_det)
            deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
    end

    // Qualification looks at the updated count so the Nth high cycle already arms ACQUIRE.
    assign qual = (deb_d == DEB_MAX);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= ST_DOWN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sc_evt    = 1'b0;
        to_evt    = 1'b0;
        loss_evt  = 1'b0;
        tmr_clr   = 1'b0;
        stb_start = 1'b0;
        stb_inc   = 1'b0;
        if (state_q != ST_DOWN && !eff_det) begin
            state_d  = ST_DOWN;
            loss_evt = (state_q == ST_UP);
        end else if (state_q != ST_DOWN && lb_toggle) begin
            state_d  = ST_ACQ;
            sc_evt   = 1'b1;
            tmr_clr  = 1'b1;
            loss_evt = (state_q == ST_UP);
        end else begin
            case (state_q)
                ST_DOWN: begin
                    if (qual) begin
                        state_d = ST_ACQ;
                        sc_evt  = 1'b1;
                        tmr_clr = 1'b1;
                    end
                end
                ST_ACQ: begin
                    if (CODE_SYNC) begin
                        state_d   = (STB_MAX == STB_ONE) ? ST_UP : ST_STABLE;
                        tmr_clr   = 1'b1;
                        stb_start = 1'b1;
                    end else if (timer_q == TMR_LAST) begin
                        to_evt  = 1'b1;
                        sc_evt  = 1'b1;
                        tmr_clr = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (CODE_SYNC) begin
                        stb_inc = 1'b1;
                        if (stable_q + 1'b1 == STB_MAX) state_d = ST_UP;
                    end else begin
                        state_d = ST_ACQ;
                        tmr_clr = 1'b1;
                    end
                end
                ST_UP: begin
                    if (!CODE_SYNC) begin
                        state_d  = ST_ACQ;
                        loss_evt = 1'b1;
                        tmr_clr  = 1'b1;
                    end
                end
                default: state_d = ST_DOWN;
            endcase
        end
    end

    always_comb begin
        timer_d  = (state_d == ST_ACQ && !tmr_clr) ? timer_q + 1'b1 : '0;
        stable_d = stable_q;
        if (stb_start)                stable_d = STB_ONE;
        else if (stb_inc)             stable_d = stable_q + 1'b1;
        else if (state_d != ST_STABLE) stable_d = '0;
        loss_d = loss_q;
        if (loss_evt && loss_q != '1) loss_d = loss_q + 1'b1;
        link_d = (state_d == ST_UP);
        sc_d   = sc_evt;
        to_d   = to_evt;
        lb_d   = MR_LOOPBACK_REQ;
        pudi_d = MR_LOOPBACK_REQ ? TX_CG : PMA_RX_CG;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            deb_q    <= '0;
            stable_q <= '0;
            timer_q  <= '0;
            loss_q   <= '0;
            pudi_q   <= '0;
            lb_q     <= 1'b0;
            link_q   <= 1'b0;
            sc_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            deb_q    <= deb_d;
            stable_q <= stable_d;
            timer_q  <= timer_d;
            loss_q   <= loss_d;
            pudi_q   <= pudi_d;
            lb_q     <= lb_d;
            link_q   <= link_d;
            sc_q     <= sc_d;
            to_q     <= to_d;
        end
    end

    assign SIGNAL_DETECT = (state_q != ST_DOWN);
    assign SIGNAL_CHANGE = sc_q;
    assign TIMEOUT       = to_q;
    assign LINK_STATUS   = link_q;
    assign MR_LOOPBACK   = lb_q;
    assign PUDI          = pudi_q;
    assign SYNC_LOSS_CNT = loss_q;
endmodule

// File: tb/tb_synch_link_ctrl.sv
// Scoreboard bench for synch_link_ctrl: expected pulses/edges and per-cycle PUDI
// values are queued as stimulus is driven and matched against the outputs on negedge.
module tb_synch_link_ctrl;
    localparam int EV_SC = 1, EV_TO = 2, EV_LINK = 3, EV_LOSS = 4;

    logic       CLK = 1'b0;
    logic       RESET, PMA_SIGNAL_DETECT, MR_LOOPBACK_REQ, CODE_SYNC;
    logic [9:0] PMA_RX_CG, TX_CG, PUDI;
    logic       SIGNAL_DETECT, SIGNAL_CHANGE, MR_LOOPBACK, LINK_STATUS, TIMEOUT;
    logic [1:0] SYNC_LOSS_CNT;

    typedef struct {int kind; int cyc; int val;} ev_t;
    typedef struct {logic [9:0] pudi; logic lb;} dp_t;
    ev_t evq[$];
    dp_t dpq[$];

    int checks = 0, errors = 0, cyc = 0;
    logic       prev_link = 1'b0;
    logic [1:0] prev_loss = '0;

    synch_link_ctrl #(.CNT_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .PMA_SIGNAL_DETECT(PMA_SIGNAL_DETECT),
        .PMA_RX_CG(PMA_RX_CG), .TX_CG(TX_CG), .MR_LOOPBACK_REQ(MR_LOOPBACK_REQ),
        .CODE_SYNC(CODE_SYNC), .SIGNAL_DETECT(SIGNAL_DETECT), .SIGNAL_CHANGE(SIGNAL_CHANGE),
        .PUDI(PUDI), .MR_LOOPBACK(MR_LOOPBACK), .LINK_STATUS(LINK_STATUS),
        .TIMEOUT(TIMEOUT), .SYNC_LOSS_CNT(SYNC_LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int at, input int val);
        evq.push_back('{kind, at, val});
    endtask

    task automatic got_ev(input int kind, input int val);
        ev_t e;
        if (evq.size() == 0) begin
            chk($sformatf("unexpected_ev_kind_at_%0d", cyc), kind, 0);
        end else begin
            e = evq.pop_front();
            chk("ev_kind", kind, e.kind);
            chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
            chk($sformatf("ev%0d_value", e.kind), val, e.val);
        end
    endtask

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RESET) dpq.push_back('{MR_LOOPBACK_REQ ? TX_CG : PMA_RX_CG, MR_LOOPBACK_REQ});
    end

    always @(negedge CLK) begin
        dp_t d;
        if (!RESET) begin
            dpq.delete();
            chk("rst_pudi", PUDI, 0);
            prev_link = 1'b0;
            prev_loss = '0;
        end else begin
            if (dpq.size() > 0) begin
                d = dpq.pop_front();
                chk("pudi", PUDI, d.pudi);
                chk("mr_loopback", MR_LOOPBACK, d.lb);
            end
            if (SIGNAL_CHANGE) got_ev(EV_SC, 1);
            if (TIMEOUT) got_ev(EV_TO, 1);
            if (LINK_STATUS !== prev_link) got_ev(EV_LINK, LINK_STATUS);
            if (SYNC_LOSS_CNT !== prev_loss) got_ev(EV_LOSS, SYNC_LOSS_CNT);
            prev_link = LINK_STATUS;
            prev_loss = SYNC_LOSS_CNT;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            PMA_RX_CG = 10'($urandom);
            TX_CG     = 10'($urandom);
            step();
        end
    endtask

    initial begin
        int c, e;
        RESET = 1'b1; PMA_SIGNAL_DETECT = 1'b0; MR_LOOPBACK_REQ = 1'b0; CODE_SYNC = 1'b0;
        PMA_RX_CG = '0; TX_CG = '0;
        #1 RESET = 1'b0;
        tick(3);
        chk("rst_sd", SIGNAL_DETECT, 0);
        chk("rst_sc", SIGNAL_CHANGE, 0);
        chk("rst_pudi_init", PUDI, 0);
        chk("rst_lb", MR_LOOPBACK, 0);
        chk("rst_link", LINK_STATUS, 0);
        chk("rst_to", TIMEOUT, 0);
        chk("rst_loss", SYNC_LOSS_CNT, 0);
        RESET = 1'b1;
        tick(2);

        // debounce glitch: high 3, low 1, high 4
        c = cyc;
        PMA_SIGNAL_DETECT = 1'b1;
        tick(3);
        chk("glitch_sd_run1", SIGNAL_DETECT, 0);
        PMA_SIGNAL_DETECT = 1'b0;
        tick(1);
        chk("glitch_sd_low", SIGNAL_DETECT, 0);
        PMA_SIGNAL_DETECT = 1'b1;
        expect_ev(EV_SC, c + 8, 1);
        tick(3);
        chk("glitch_sd_run2", SIGNAL_DETECT, 0);
        tick(1);
        chk("glitch_sd_qual", SIGNAL_DETECT, 1);

        // acquisition timeout with CODE_SYNC held low
        e = c + 8;
        expect_ev(EV_SC, e + 1024, 1);
        expect_ev(EV_TO, e + 1024, 1);
        expect_ev(EV_SC, e + 2048, 1);
        expect_ev(EV_TO, e + 2048, 1);
        tick(2049);
        chk("timeout_link", LINK_STATUS, 0);
        PMA_SIGNAL_DETECT = 1'b0;
        tick(1);
        chk("drop_to_down_sd", SIGNAL_DETECT, 0);
        chk("drop_no_loss", SYNC_LOSS_CNT, 0);

        // bring-up
        PMA_RX_CG = 10'b1100000101;
        step();
        chk("pudi_rx_k28", PUDI, 10'b1100000101);
        c = cyc;
        PMA_SIGNAL_DETECT = 1'b1;
        expect_ev(EV_SC, c + 4, 1);
        tick(3);
        chk("bringup_sd_pre", SIGNAL_DETECT, 0);
        tick(1);
        chk("bringup_sd", SIGNAL_DETECT, 1);
        tick(3);
        CODE_SYNC = 1'b1;
        expect_ev(EV_LINK, cyc + 16, 1);
        tick(15);
        chk("bringup_link_pre", LINK_STATUS, 0);
        tick(1);
        chk("bringup_link", LINK_STATUS, 1);

        // loopback from UP, then PMA detect removed
        c = cyc;
        MR_LOOPBACK_REQ = 1'b1;
        expect_ev(EV_SC, c + 1, 1);
        expect_ev(EV_LINK, c + 1, 0);
        expect_ev(EV_LOSS, c + 1, 1);
        expect_ev(EV_LINK, c + 17, 1);
        tick(1);
        chk("lb_reg", MR_LOOPBACK, 1);
        chk("lb_loss", SYNC_LOSS_CNT, 1);
        PMA_SIGNAL_DETECT = 1'b0;
        tick(1);
        chk("lb_not_down", SIGNAL_DETECT, 1);
        TX_CG = 10'b0011111010;
        PMA_RX_CG = '0;
        step();
        chk("pudi_tx", PUDI, 10'b0011111010);
        tick(14);
        chk("lb_link_up", LINK_STATUS, 1);

        // back to PMA source: toggle with detect present
        c = cyc;
        MR_LOOPBACK_REQ = 1'b0;
        PMA_SIGNAL_DETECT = 1'b1;
        expect_ev(EV_SC, c + 1, 1);
        expect_ev(EV_LINK, c + 1, 0);
        expect_ev(EV_LOSS, c + 1, 2);
        expect_ev(EV_LINK, c + 17, 1);
        tick(17);
        chk("unlb_link_up", LINK_STATUS, 1);

        // detect drop and loopback rise together: toggle rule wins
        c = cyc;
        PMA_SIGNAL_DETECT = 1'b0;
        MR_LOOPBACK_REQ = 1'b1;
        CODE_SYNC = 1'b0;
        expect_ev(EV_SC, c + 1, 1);
        expect_ev(EV_LINK, c + 1, 0);
        expect_ev(EV_LOSS, c + 1, 3);
        tick(1);
        chk("prio_not_down", SIGNAL_DETECT, 1);
        chk("prio_loss", SYNC_LOSS_CNT, 3);
        tick(3);
        RESET = 1'b0;
        #1;
        chk("async_rst_sd", SIGNAL_DETECT, 0);
        chk("async_rst_sc", SIGNAL_CHANGE, 0);
        chk("async_rst_pudi", PUDI, 0);
        chk("async_rst_lb", MR_LOOPBACK, 0);
        chk("async_rst_link", LINK_STATUS, 0);
        chk("async_rst_to", TIMEOUT, 0);
        chk("async_rst_loss", SYNC_LOSS_CNT, 0);
        MR_LOOPBACK_REQ = 1'b0;
        tick(2);
        RESET = 1'b1;
        tick(6);
        chk("post_rst_sd", SIGNAL_DETECT, 0);
        chk("post_rst_sc", SIGNAL_CHANGE, 0);

        // sync loss and counter saturation
        c = cyc;
        PMA_SIGNAL_DETECT = 1'b1;
        expect_ev(EV_SC, c + 4, 1);
        tick(4);
        CODE_SYNC = 1'b1;
        expect_ev(EV_LINK, cyc + 16, 1);
        tick(16);
        chk("loss_link_up", LINK_STATUS, 1);
        for (int i = 1; i <= 5; i++) begin
            c = cyc;
            CODE_SYNC = 1'b0;
            expect_ev(EV_LINK, c + 1, 0);
            if (i <= 3) expect_ev(EV_LOSS, c + 1, i);
            tick(1);
            chk("loss_link_fall", LINK_STATUS, 0);
            chk("loss_cnt", SYNC_LOSS_CNT, (i < 3) ? i : 3);
            CODE_SYNC = 1'b1;
            expect_ev(EV_LINK, cyc + 16, 1);
            tick(16);
            chk("loss_link_rise", LINK_STATUS, 1);
        end

        tick(3);
        chk("evq_drained", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/synch_link_ctrl.md
Name: synch_link_ctrl

Overview:
Link bring-up controller that sequences the code-group synchronization block. It qualifies the raw PMA signal-detect, issues re-sync pulses, and selects the PUDI source between the PMA receive path and TX loopback. It monitors CODE_SYNC to declare link status, detect acquisition timeouts, and count sync losses. It sits between the PMA receive interface and the synchronization block; its outputs drive that block's SIGNAL_DETECT, SIGNAL_CHANGE, PUDI and MR_LOOPBACK inputs.

Parameters:
DEBOUNCE_CYC, 4, consecutive cycles PMA_SIGNAL_DETECT must be high before detect is qualified (>=1)
SYNC_STABLE_CYC, 16, consecutive CODE_SYNC=1 cycles required before LINK_STATUS asserts (>=1)
ACQ_TIMEOUT_CYC, 1024, cycles in ACQUIRE without CODE_SYNC before timeout and re-arm (>=2)
CNT_W, 8, width of SYNC_LOSS_CNT

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-low reset
PMA_SIGNAL_DETECT  input  1  raw signal-detect from PMA
PMA_RX_CG  input  10  received code-group from PMA
TX_CG  input  10  transmit code-group, loopback source
MR_LOOPBACK_REQ  input  1  management loopback request
CODE_SYNC  input  1  sync-acquired status from synchronization block
SIGNAL_DETECT  output  1  qualified detect to synchronization block
SIGNAL_CHANGE  output  1  one-cycle re-sync pulse to synchronization block
PUDI  output  10  selected code-group to synchronization block
MR_LOOPBACK  output  1  registered loopback select
LINK_STATUS  output  1  link up
TIMEOUT  output  1  one-cycle pulse on acquisition timeout
SYNC_LOSS_CNT  output  CNT_W  saturating count of link drops from UP

Behaviour:
- Reset (RESET=0, async): state DOWN; all outputs 0; debounce, stable and timeout counters 0.
- MR_LOOPBACK = MR_LOOPBACK_REQ registered, 1-cycle latency.
- PUDI registered: MR_LOOPBACK_REQ ? TX_CG : PMA_RX_CG, 1-cycle latency, updated every cycle in all states.
- eff_det = MR_LOOPBACK_REQ | PMA_SIGNAL_DETECT. A loopback toggle is an edge of MR_LOOPBACK_REQ against its registered copy.
- Debounce counter: increments while eff_det=1, saturating at DEBOUNCE_CYC. It clears to 0 on any eff_det=0 cycle. qual = counter reached DEBOUNCE_CYC. Deassertion is immediate: a single eff_det=0 cycle drops qual.
- SIGNAL_DETECT = 1 in ACQUIRE, STABLE and UP; 0 in DOWN.
- States, with priority top to bottom each cycle:
  1. eff_det=0 in any non-DOWN state -> DOWN. If leaving UP, SYNC_LOSS_CNT += 1.
  2. Loopback toggle in a non-DOWN state -> ACQUIRE; pulse SIGNAL_CHANGE; timer clears. If leaving UP, SYNC_LOSS_CNT += 1.
  3. Per-state rules:
     - DOWN: when qual is reached -> ACQUIRE; SIGNAL_CHANGE=1 for exactly one cycle, coincident with the first SIGNAL_DETECT=1 cycle.
     - ACQUIRE: timer increments each cycle.
       - CODE_SYNC=1 -> STABLE; timer clears; stable count = 1.
       - Else, timer = ACQ_TIMEOUT_CYC-1 -> TIMEOUT pulse and SIGNAL_CHANGE pulse in the same cycle; timer clears; stay in ACQUIRE.
     - STABLE: CODE_SYNC=1 increments the stable count. When the count reaches SYNC_STABLE_CYC -> UP. CODE_SYNC=0 -> ACQUIRE, no counter increment.
     - UP: LINK_STATUS=1 (registered, asserts the cycle the state becomes UP). CODE_SYNC=0 -> ACQUIRE; SYNC_LOSS_CNT += 1; LINK_STATUS=0 next cycle.
- SYNC_LOSS_CNT saturates at 2^CNT_W-1; it never wraps. It is cleared only by reset.
- SIGNAL_CHANGE and TIMEOUT are never high for two consecutive cycles from a single event.
- RESET asserted mid-operation: all outputs drop to reset values immediately; no pulse is emitted on release.

Test Plan:
1. Bring-up: release RESET, PMA_SIGNAL_DETECT=1, CODE_SYNC rises 3 cycles after SIGNAL_CHANGE, PMA_RX_CG=10'b1100000101 -> SIGNAL_DETECT and SIGNAL_CHANGE both high in the 4th cycle after detect rises; PUDI=10'b1100000101 one cycle after input; LINK_STATUS=1 exactly 16 cycles after CODE_SYNC rises.
2. Debounce glitch: PMA_SIGNAL_DETECT high 3 cycles, low 1, high 4 -> no SIGNAL_CHANGE until the 4th cycle of the second high run; SIGNAL_DETECT stays 0 throughout the glitch.
3. Timeout: detect qualified, CODE_SYNC held 0 -> TIMEOUT and SIGNAL_CHANGE pulse together every 1024 cycles; LINK_STATUS stays 0.
4. Sync loss and saturation (CNT_W=2): link UP, drop CODE_SYNC for 1 cycle, repeat 5 times -> LINK_STATUS falls each time; SYNC_LOSS_CNT reads 1, 2, 3, 3, 3.
5. Loopback: link UP with PMA_SIGNAL_DETECT=1, assert MR_LOOPBACK_REQ, then deassert PMA_SIGNAL_DETECT -> MR_LOOPBACK=1 next cycle; SIGNAL_CHANGE pulse; SYNC_LOSS_CNT +1; PUDI follows TX_CG; state does not go to DOWN.
6. Priority and reset: in UP, drop PMA_SIGNAL_DETECT and toggle MR_LOOPBACK_REQ in the same cycle with the request going high -> the loopback-toggle rule applies (not DOWN), because loopback forces eff_det=1. Then assert RESET mid-ACQUIRE -> all outputs 0 asynchronously, state DOWN.
